// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the data-memory bus: CPU has priority, DMA steals idle
// cycles and forces a slot after waiting STARVE_LIMIT busy cycles.
module dmem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter logic [31:0] PERIPH_BASE  = 32'h4000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cpu_Address,
    input  logic [31:0] cpu_Write_data,
    input  logic        cpu_MemRead,
    input  logic        cpu_MemWrite,
    output logic [31:0] cpu_Read_data,
    output logic        cpu_stall,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_Address,
    input  logic [31:0] dma_Write_data,
    output logic        dma_ack,
    output logic        dma_err,
    output logic [31:0] dma_Read_data,
    output logic [31:0] Address,
    output logic [31:0] Write_data,
    output logic        MemRead,
    output logic        MemWrite,
    input  logic [31:0] Read_data
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FORCE, S_ACK} state_t;

    localparam logic [7:0] LIMIT_M1 = 8'(STARVE_LIMIT - 1);

    state_t     state, state_nxt;
    logic [7:0] wait_cnt, wait_cnt_nxt;
    logic       cpu_busy;
    logic       reject;
    logic       dma_bus;

    assign cpu_busy = cpu_MemRead | cpu_MemWrite;
    assign reject   = dma_we && (dma_Address >= PERIPH_BASE);

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        dma_bus      = 1'b0;
        case (state)
            S_IDLE: begin
                if (dma_req) begin
                    state_nxt    = S_WAIT;
                    wait_cnt_nxt = '0;
                end
            end
            S_WAIT: begin
                if (!cpu_busy) begin
                    dma_bus   = 1'b1;
                    state_nxt = S_ACK;
                end else begin
                    // Counter saturates; the limit compare uses the pre-increment value.
                    if (wait_cnt != '1)
                        wait_cnt_nxt = wait_cnt + 8'd1;
                    if (wait_cnt == LIMIT_M1)
                        state_nxt = S_FORCE;
                end
            end
            S_FORCE: begin
                dma_bus   = 1'b1;
                state_nxt = S_ACK;
            end
            S_ACK:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        Address       = cpu_Address;
        Write_data    = cpu_Write_data;
        MemRead       = cpu_MemRead;
        MemWrite      = cpu_MemWrite;
        cpu_Read_data = Read_data;
        cpu_stall     = (state == S_FORCE) && cpu_busy;
        if (dma_bus) begin
            Address       = dma_Address;
            Write_data    = dma_Write_data;
            MemRead       = !dma_we;
            MemWrite      = dma_we && !reject;
            cpu_Read_data = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= S_IDLE;
            wait_cnt      <= '0;
            dma_ack       <= 1'b0;
            dma_err       <= 1'b0;
            dma_Read_data <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            dma_ack  <= dma_bus;
            dma_err  <= dma_bus && reject;
            if (dma_bus && !dma_we)
                dma_Read_data <= Read_data;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: expected DMA completions are queued by the
// stimulus and checked by a negedge monitor; bus/stall behaviour checked directly.
module tb_dmem_arbiter;

    localparam int unsigned SL         = 4;
    localparam logic [31:0] PERIPH     = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] cpu_Address, cpu_Write_data, cpu_Read_data;
    logic        cpu_MemRead, cpu_MemWrite, cpu_stall;
    logic        dma_req, dma_we, dma_ack, dma_err;
    logic [31:0] dma_Address, dma_Write_data, dma_Read_data;
    logic [31:0] Address, Write_data, Read_data;
    logic        MemRead, MemWrite;

    logic [31:0] mem    [0:255];
    logic [31:0] periph [0:15];

    typedef struct {
        logic        err;
        logic [31:0] rd;
        int unsigned cyc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int unsigned cyc = 0;
    int unsigned stall_cnt = 0;
    int unsigned periph_wr_cnt = 0;
    int unsigned n_checks = 0;
    int unsigned n_pass = 0;

    dmem_arbiter #(.STARVE_LIMIT(SL), .PERIPH_BASE(PERIPH)) dut (
        .clk            (clk),
        .reset          (reset),
        .cpu_Address    (cpu_Address),
        .cpu_Write_data (cpu_Write_data),
        .cpu_MemRead    (cpu_MemRead),
        .cpu_MemWrite   (cpu_MemWrite),
        .cpu_Read_data  (cpu_Read_data),
        .cpu_stall      (cpu_stall),
        .dma_req        (dma_req),
        .dma_we         (dma_we),
        .dma_Address    (dma_Address),
        .dma_Write_data (dma_Write_data),
        .dma_ack        (dma_ack),
        .dma_err        (dma_err),
        .dma_Read_data  (dma_Read_data),
        .Address        (Address),
        .Write_data     (Write_data),
        .MemRead        (MemRead),
        .MemWrite       (MemWrite),
        .Read_data      (Read_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: preloaded on the first edge after reset is released.
    assign Read_data = (Address >= PERIPH) ? periph[Address[5:2]] : mem[Address[9:2]];

    always @(posedge clk) begin
        if (cyc == 2) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
            for (int i = 0; i < 16; i++) periph[i] <= 32'hA5A5_0000 | 32'(i);
            mem[8]    <= 32'h1234_5678;
            mem[12]   <= 32'hCAFE_F00D;
            periph[3] <= 32'h0000_0005;
        end else if (MemWrite) begin
            if (Address >= PERIPH) begin
                periph[Address[5:2]] <= Write_data;
                periph_wr_cnt <= periph_wr_cnt + 1;
            end else begin
                mem[Address[9:2]] <= Write_data;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (cpu_stall) stall_cnt <= stall_cnt + 1;
        if (dma_ack) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ack", 32'(dma_ack), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("ack_cycle", 32'(cyc), 32'(mon_e.cyc));
                check("dma_err", 32'(dma_err), 32'(mon_e.err));
                check("dma_Read_data", dma_Read_data, mon_e.rd);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dma_xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic exp_err, input logic [31:0] exp_rd);
        bit got;
        int unsigned n;
        exp_q.push_back('{exp_err, exp_rd, cyc + 2});
        dma_req        = 1'b1;
        dma_we         = we;
        dma_Address    = addr;
        dma_Write_data = wdata;
        got = 1'b0;
        n   = 0;
        while (!got && n < 40) begin
            @(negedge clk);
            if (dma_ack) got = 1'b1;
            n++;
        end
        if (!got) check("dma_ack_timeout", 32'(got), 32'd1);
        tick();
        dma_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int unsigned k, s0, p0;

        // Reset with random inputs
        reset = 1'b0;
        cpu_Address = $urandom; cpu_Write_data = $urandom;
        cpu_MemRead = 1'($urandom); cpu_MemWrite = 1'($urandom);
        dma_req = 1'($urandom); dma_we = 1'($urandom);
        dma_Address = $urandom; dma_Write_data = $urandom;
        tick();
        cpu_Address = $urandom; cpu_Write_data = $urandom;
        cpu_MemRead = 1'b1; cpu_MemWrite = 1'($urandom);
        dma_req = 1'b1; dma_Address = $urandom;
        tick();
        check("rst_dma_ack", 32'(dma_ack), 32'd0);
        check("rst_dma_err", 32'(dma_err), 32'd0);
        check("rst_dma_Read_data", dma_Read_data, 32'd0);
        check("rst_cpu_stall", 32'(cpu_stall), 32'd0);
        check("rst_Address", Address, cpu_Address);
        check("rst_Write_data", Write_data, cpu_Write_data);
        check("rst_MemRead", 32'(MemRead), 32'(cpu_MemRead));
        check("rst_MemWrite", 32'(MemWrite), 32'(cpu_MemWrite));

        reset = 1'b1;
        cpu_Address = '0; cpu_Write_data = '0; cpu_MemRead = 1'b0; cpu_MemWrite = 1'b0;
        dma_req = 1'b0; dma_we = 1'b0; dma_Address = '0; dma_Write_data = '0;
        tick();
        tick();

        // Idle steal: write then read back, CPU idle
        s0 = stall_cnt;
        dma_xfer(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0);
        dma_xfer(1'b0, 32'h0000_0010, 32'h0, 1'b0, 32'hDEAD_BEEF);
        check("mem_0x10", mem[4], 32'hDEAD_BEEF);
        check("steal_no_stall", 32'(stall_cnt - s0), 32'd0);

        // Starvation: CPU loads every cycle, DMA read forced after SL busy cycles
        s0 = stall_cnt;
        k  = cyc;
        cpu_MemRead = 1'b1; cpu_Address = 32'h0000_0020;
        dma_req = 1'b1; dma_we = 1'b0; dma_Address = 32'h0000_0030;
        exp_q.push_back('{1'b0, 32'hCAFE_F00D, k + SL + 2});
        for (int i = 1; i <= int'(SL); i++) begin
            tick();
            check("wait_cpu_stall", 32'(cpu_stall), 32'd0);
            check("wait_Address", Address, 32'h0000_0020);
            check("wait_cpu_Read_data", cpu_Read_data, 32'h1234_5678);
        end
        tick();
        check("force_cpu_stall", 32'(cpu_stall), 32'd1);
        check("force_Address", Address, 32'h0000_0030);
        check("force_MemRead", 32'(MemRead), 32'd1);
        check("force_cpu_Read_data", cpu_Read_data, 32'd0);
        tick();
        check("ack_cpu_stall", 32'(cpu_stall), 32'd0);
        check("ack_cpu_Read_data", cpu_Read_data, 32'h1234_5678);
        dma_req = 1'b0;
        tick();
        cpu_MemRead = 1'b0;
        check("starve_stall_cycles", 32'(stall_cnt - s0), 32'd1);
        tick();

        // Peripheral protection
        p0 = periph_wr_cnt;
        dma_xfer(1'b1, 32'h4000_000C, 32'h0000_00FF, 1'b1, 32'hCAFE_F00D);
        check("periph_no_write", 32'(periph_wr_cnt - p0), 32'd0);
        check("led_reg", periph[3], 32'h0000_0005);
        dma_xfer(1'b0, 32'h4000_0014, 32'h0, 1'b0, 32'hA5A5_0005);

        // Reset asserted during FORCE aborts the transfer
        cpu_MemRead = 1'b1; cpu_Address = 32'h0000_0020;
        dma_req = 1'b1; dma_we = 1'b0; dma_Address = 32'h0000_0030;
        for (int i = 0; i <= int'(SL); i++) tick();
        check("pre_rst_force_stall", 32'(cpu_stall), 32'd1);
        reset = 1'b0;
        tick();
        check("post_rst_cpu_stall", 32'(cpu_stall), 32'd0);
        check("post_rst_dma_ack", 32'(dma_ack), 32'd0);
        check("post_rst_dma_Read_data", dma_Read_data, 32'd0);
        reset = 1'b1; dma_req = 1'b0; cpu_MemRead = 1'b0;
        tick();
        dma_xfer(1'b0, 32'h0000_0010, 32'h0, 1'b0, 32'hDEAD_BEEF);

        // Back-to-back with dma_req held high: acks 3 cycles apart
        k = cyc;
        exp_q.push_back('{1'b0, 32'hDEAD_BEEF, k + 2});
        exp_q.push_back('{1'b0, 32'hDEAD_BEEF, k + 5});
        exp_q.push_back('{1'b0, 32'h1111_1111, k + 8});
        dma_req = 1'b1; dma_we = 1'b1; dma_Address = 32'h0000_0040; dma_Write_data = 32'h1111_1111;
        repeat (3) tick();
        dma_Address = 32'h0000_0044; dma_Write_data = 32'h2222_2222;
        repeat (3) tick();
        dma_we = 1'b0; dma_Address = 32'h0000_0040;
        repeat (3) tick();
        dma_req = 1'b0;
        repeat (3) tick();
        check("b2b_mem_0x44", mem[17], 32'h2222_2222);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-master arbiter for the shared data-memory/peripheral bus. It sits between the pipeline's MEM-stage load/store port and the DataMemory bus, and adds a second requester: a DMA port used by I/O engines. The CPU keeps priority. The DMA steals idle bus cycles, and it gets a forced slot, stalling the CPU, once it has waited STARVE_LIMIT cycles.

## Interface
- STARVE_LIMIT, 4: number of busy CPU cycles a pending DMA request tolerates before it forces a slot. Legal range 1..255.
- PERIPH_BASE, 32'h40000000: addresses at or above this value are the peripheral region.
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset (reset==0 at posedge clk resets).
- cpu_Address  in  32  CPU byte address.
- cpu_Write_data  in  32  CPU store data.
- cpu_MemRead, cpu_MemWrite  in  1 each  CPU access strobes.
- cpu_Read_data  out  32  load data to CPU; 0 whenever the DMA owns the bus.
- cpu_stall  out  1  combinational; freeze the pipeline and re-issue the access next cycle.
- dma_req  in  1  DMA request, level; held with stable address/data until dma_ack.
- dma_we  in  1  1 = write, 0 = read.
- dma_Address, dma_Write_data  in  32 each  DMA address and write data.
- dma_ack  out  1  one-cycle completion pulse.
- dma_err  out  1  valid with dma_ack; access rejected.
- dma_Read_data  out  32  registered read data, valid with dma_ack.
- Address, Write_data  out  32 each  to the memory bus.
- MemRead, MemWrite  out  1 each  to the memory bus.
- Read_data  in  32  combinational read data from the memory bus.

## Operation
- FSM states: IDLE, WAIT, FORCE, ACK.
- IDLE:
  - Bus follows the CPU (pass-through); cpu_stall=0.
  - dma_req=1 -> WAIT; clear wait_cnt.
- WAIT:
  - CPU idle this cycle (!cpu_MemRead && !cpu_MemWrite): the bus carries the DMA access this cycle, dma_Read_data captures Read_data, -> ACK.
  - CPU busy: the CPU keeps the bus and wait_cnt increments.
  - wait_cnt reaching STARVE_LIMIT-1 on a busy cycle -> FORCE.
- FORCE:
  - The bus carries the DMA access unconditionally; dma_Read_data captures Read_data; -> ACK.
  - cpu_stall = cpu_MemRead | cpu_MemWrite.
  - CPU strobes are not forwarded.
- ACK:
  - dma_ack=1 for exactly one cycle; the bus follows the CPU; -> IDLE.
  - dma_req still high in ACK is not a new request. It is sampled again in IDLE on the following cycle, so back-to-back transfers have a minimum spacing of 3 cycles.
- Protection: a DMA write with dma_Address >= PERIPH_BASE is rejected. MemWrite stays 0, the transfer completes normally through ACK, and dma_err=1 with dma_ack. DMA reads of the peripheral region are allowed.
- When the DMA owns the bus: MemRead = !dma_we; MemWrite = dma_we & !reject.
- dma_Read_data:
  - Updated only on the DMA bus cycle, for reads.
  - DMA writes leave it unchanged.
  - It holds its value otherwise.
- wait_cnt is 8 bits and saturates. It is cleared on every entry to WAIT and never wraps.

## Timing
- Reset values (reset==0 at posedge): state=IDLE, wait_cnt=0, dma_ack=0, dma_err=0, dma_Read_data=0. cpu_stall=0 and bus outputs follow the CPU from the next cycle.
- Reset asserted in WAIT/FORCE/ACK aborts the transfer: no ack is issued, and any write already on the bus in the current cycle still lands.
- Latency from dma_req rising to dma_ack:
  - Best case with the CPU idle: 3 cycles (IDLE->WAIT, bus cycle, ACK).
  - Worst case with the CPU always busy: STARVE_LIMIT+3 cycles.
- At most one CPU stall cycle per DMA transfer.
- The CPU stalls only in FORCE, and only if it has an access pending.
- The CPU and DMA never drive the bus in the same cycle.
- Simultaneous events:
  - CPU access and first WAIT cycle: the CPU wins.
  - CPU access and FORCE: the DMA wins.
- STARVE_LIMIT=1: the first busy cycle in WAIT goes to FORCE on the next cycle.

## Test plan
- Reset: hold reset=0 for 2 cycles with random inputs -> dma_ack=0, dma_err=0, dma_Read_data=0, cpu_stall=0, bus equals the CPU inputs.
- Idle steal: CPU idle, DMA write 0x0000_0010 <- 0xDEADBEEF, then DMA read 0x10 -> first dma_ack 3 cycles after req with dma_err=0; read ack carries dma_Read_data=0xDEADBEEF; cpu_stall never asserted.
- Starvation: STARVE_LIMIT=4, CPU issues a load every cycle, DMA read pending -> exactly 4 busy WAIT cycles, then one FORCE cycle with cpu_stall=1 and MemRead driven by DMA; dma_ack the next cycle; the CPU load completes one cycle late with correct data.
- Peripheral protect: DMA write 0x4000_000C <- 0xFF -> MemWrite never 1 for the DMA; dma_ack=1 with dma_err=1; LED register unchanged. DMA read 0x4000_0014 -> dma_err=0.
- Reset mid-operation: assert reset in FORCE -> no dma_ack; state IDLE; cpu_stall=0 next cycle; a fresh request completes normally.
- Back-to-back: dma_req held high across 3 transfers with the CPU idle -> acks on cycles 3, 6, 9, each ack exactly 1 cycle wide.
